// File: rtl/dmem_port_arbiter.sv
// Two-hart arbiter for the shared data-memory port: round-robin selection,
// AMO word lock with owner tracking, flush drain and a sticky lock watchdog.
module dmem_port_arbiter #(
  parameter int unsigned MAX_LOCK_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] req_addr_0,
  input  logic [31:0] req_addr_1,
  input  logic [3:0]  req_rmask_0,
  input  logic [3:0]  req_rmask_1,
  input  logic [3:0]  req_wmask_0,
  input  logic [3:0]  req_wmask_1,
  input  logic [31:0] req_wdata_0,
  input  logic [31:0] req_wdata_1,
  output logic [31:0] req_rdata_0,
  output logic [31:0] req_rdata_1,
  output logic        req_resp_0,
  output logic        req_resp_1,
  input  logic        lock_0,
  input  logic        lock_1,
  input  logic [31:0] lock_addr_0,
  input  logic [31:0] lock_addr_1,
  input  logic        flush_0,
  input  logic        flush_1,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp,
  output logic        grant_id,
  output logic        lock_timeout
);

  localparam int unsigned WDOG_W = $clog2(MAX_LOCK_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(MAX_LOCK_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic              rr_q, rr_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        rmask_q, rmask_d;
  logic [3:0]        wmask_q, wmask_d;
  logic [31:0]       rdata0_q, rdata0_d;
  logic [31:0]       rdata1_q, rdata1_d;
  logic              owner_valid_q, owner_valid_d;
  logic              owner_id_q, owner_id_d;
  logic [31:0]       owner_addr_q, owner_addr_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              timeout_q, timeout_d;

  logic [1:0] pending, addr_hit, blocked, eligible, lock_in, flush_in;
  logic       sel_id, acq_id, release_lock, grant_flush, resp_fire;

  assign lock_in  = {lock_1, lock_0};
  assign flush_in = {flush_1, flush_0};

  // Lock match ignores byte offset: the whole word is protected.
  always_comb begin
    pending[0]  = (|(req_rmask_0 | req_wmask_0)) && !flush_0;
    pending[1]  = (|(req_rmask_1 | req_wmask_1)) && !flush_1;
    addr_hit[0] = ((req_addr_0 ^ owner_addr_q) & 32'hFFFF_FFFC) == 32'h0;
    addr_hit[1] = ((req_addr_1 ^ owner_addr_q) & 32'hFFFF_FFFC) == 32'h0;
    blocked[0]  = (owner_valid_q && owner_id_q && addr_hit[0])
               || (lock_0 && !(owner_valid_q && !owner_id_q));
    blocked[1]  = (owner_valid_q && !owner_id_q && addr_hit[1])
               || (lock_1 && !(owner_valid_q && owner_id_q));
    eligible     = pending & ~blocked;
    sel_id       = (eligible == 2'b11) ? rr_q : eligible[1];
    acq_id       = (lock_in == 2'b11) ? rr_q : lock_in[1];
    release_lock = owner_valid_q && (!lock_in[owner_id_q] || flush_in[owner_id_q]);
    grant_flush  = flush_in[grant_q];
    resp_fire    = (state_q == BUSY) && mem_resp && !grant_flush;
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_d          = rr_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rmask_d       = rmask_q;
    wmask_d       = wmask_q;
    rdata0_d      = rdata0_q;
    rdata1_d      = rdata1_q;
    owner_valid_d = owner_valid_q;
    owner_id_d    = owner_id_q;
    owner_addr_d  = owner_addr_q;
    wdog_d        = wdog_q;
    timeout_d     = timeout_q;

    case (state_q)
      IDLE: begin
        if (|eligible) begin
          state_d = BUSY;
          grant_d = sel_id;
          rr_d    = ~sel_id;
          addr_d  = sel_id ? req_addr_1  : req_addr_0;
          wdata_d = sel_id ? req_wdata_1 : req_wdata_0;
          rmask_d = sel_id ? req_rmask_1 : req_rmask_0;
          wmask_d = sel_id ? req_wmask_1 : req_wmask_0;
        end
      end
      BUSY: begin
        if (mem_resp) begin
          state_d = IDLE;
          rmask_d = '0;
          wmask_d = '0;
        end else if (grant_flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_resp) begin
          state_d = IDLE;
          rmask_d = '0;
          wmask_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        rmask_d = '0;
        wmask_d = '0;
      end
    endcase

    if (resp_fire && !grant_q) rdata0_d = mem_rdata;
    if (resp_fire && grant_q)  rdata1_d = mem_rdata;

    // Arbitration above saw the pre-update owner; ownership changes land next cycle.
    if (owner_valid_q) begin
      if (wdog_q == WDOG_MAX) timeout_d = 1'b1;
      if (release_lock) begin
        owner_valid_d = 1'b0;
        wdog_d        = '0;
      end else if (wdog_q != WDOG_MAX) begin
        wdog_d = wdog_q + WDOG_W'(1);
      end
    end else if (|lock_in) begin
      owner_valid_d = 1'b1;
      owner_id_d    = acq_id;
      owner_addr_d  = acq_id ? lock_addr_1 : lock_addr_0;
      wdog_d        = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= 1'b0;
      rr_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rmask_q       <= '0;
      wmask_q       <= '0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
      owner_valid_q <= 1'b0;
      owner_id_q    <= 1'b0;
      owner_addr_q  <= '0;
      wdog_q        <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      rr_q          <= rr_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rmask_q       <= rmask_d;
      wmask_q       <= wmask_d;
      rdata0_q      <= rdata0_d;
      rdata1_q      <= rdata1_d;
      owner_valid_q <= owner_valid_d;
      owner_id_q    <= owner_id_d;
      owner_addr_q  <= owner_addr_d;
      wdog_q        <= wdog_d;
      timeout_q     <= timeout_d;
    end
  end

  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign mem_rmask    = rmask_q;
  assign mem_wmask    = wmask_q;
  assign grant_id     = grant_q;
  assign lock_timeout = timeout_q;
  assign req_resp_0   = resp_fire && !grant_q;
  assign req_resp_1   = resp_fire && grant_q;
  assign req_rdata_0  = req_resp_0 ? mem_rdata : rdata0_q;
  assign req_rdata_1  = req_resp_1 ? mem_rdata : rdata1_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios plus random traffic, all
// checked every cycle against a transaction-level reference model.
module tb_dmem_port_arbiter;

  localparam int unsigned MAXL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a[2], wd[2], la[2];
  logic [3:0]  rm[2], wm[2];
  logic        lk[2], fl[2];
  logic        mresp;
  logic [31:0] mrdata;

  logic [31:0] req_rdata_0, req_rdata_1, mem_addr, mem_wdata;
  logic        req_resp_0, req_resp_1, grant_id, lock_timeout;
  logic [3:0]  mem_rmask, mem_wmask;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.MAX_LOCK_CYCLES(MAXL)) dut (
    .clk(clk), .rst(rst),
    .req_addr_0(a[0]), .req_addr_1(a[1]),
    .req_rmask_0(rm[0]), .req_rmask_1(rm[1]),
    .req_wmask_0(wm[0]), .req_wmask_1(wm[1]),
    .req_wdata_0(wd[0]), .req_wdata_1(wd[1]),
    .req_rdata_0(req_rdata_0), .req_rdata_1(req_rdata_1),
    .req_resp_0(req_resp_0), .req_resp_1(req_resp_1),
    .lock_0(lk[0]), .lock_1(lk[1]),
    .lock_addr_0(la[0]), .lock_addr_1(la[1]),
    .flush_0(fl[0]), .flush_1(fl[1]),
    .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_rdata(mrdata), .mem_resp(mresp),
    .grant_id(grant_id), .lock_timeout(lock_timeout)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: one in-flight transaction record, a lock owner number
  // (-1 = nobody) with its age, and the last data handed to each hart.
  bit          txn_live, txn_dead;
  int          txn_who;
  logic [3:0]  txn_rm, txn_wm;
  logic [31:0] last_addr, last_wdata;
  logic [31:0] last_rd[2];
  int          lk_owner, lk_age, rr, gnt;
  logic [29:0] lk_word;
  bit          tmo;
  bit          m_resp[2];

  bit          o_resp[2];
  logic [31:0] o_rd[2];
  logic [3:0]  o_rmask, o_wmask;
  logic        o_gnt, o_tmo;

  task automatic model_reset();
    txn_live = 0; txn_dead = 0; txn_who = 0;
    txn_rm = '0; txn_wm = '0;
    last_addr = '0; last_wdata = '0;
    last_rd[0] = '0; last_rd[1] = '0;
    lk_owner = -1; lk_age = 0; rr = 0; gnt = 0;
    lk_word = '0; tmo = 0;
  endtask

  task automatic step();
    bit el[2];
    int pick, acq;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      m_resp[k] = txn_live && !txn_dead && mresp && (txn_who == k) && !fl[k];
      el[k] = ((rm[k] | wm[k]) != 4'h0) && !fl[k]
           && !(lk_owner == 1 - k && a[k][31:2] == lk_word)
           && !(lk[k] && lk_owner != k);
    end
    o_resp[0] = req_resp_0; o_resp[1] = req_resp_1;
    o_rd[0] = req_rdata_0; o_rd[1] = req_rdata_1;
    o_rmask = mem_rmask; o_wmask = mem_wmask;
    o_gnt = grant_id; o_tmo = lock_timeout;
    check_eq("resp0", 32'(req_resp_0), 32'(m_resp[0]));
    check_eq("resp1", 32'(req_resp_1), 32'(m_resp[1]));
    check_eq("rdata0", req_rdata_0, m_resp[0] ? mrdata : last_rd[0]);
    check_eq("rdata1", req_rdata_1, m_resp[1] ? mrdata : last_rd[1]);
    check_eq("mem_addr", mem_addr, last_addr);
    check_eq("mem_wdata", mem_wdata, last_wdata);
    check_eq("mem_rmask", 32'(mem_rmask), 32'(txn_live ? txn_rm : 4'h0));
    check_eq("mem_wmask", 32'(mem_wmask), 32'(txn_live ? txn_wm : 4'h0));
    check_eq("grant_id", 32'(grant_id), 32'(gnt));
    check_eq("lock_timeout", 32'(lock_timeout), 32'(tmo));
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      pick = -1;
      if (!txn_live) begin
        if (el[0] && el[1]) pick = rr;
        else if (el[0])     pick = 0;
        else if (el[1])     pick = 1;
      end
      acq = -1;
      if (lk_owner < 0) begin
        if (lk[0] && lk[1]) acq = rr;
        else if (lk[0])     acq = 0;
        else if (lk[1])     acq = 1;
      end
      for (int k = 0; k < 2; k++) if (m_resp[k]) last_rd[k] = mrdata;
      if (txn_live) begin
        if (mresp)              txn_live = 0;
        else if (fl[txn_who])   txn_dead = 1;
      end else if (pick >= 0) begin
        txn_live = 1; txn_dead = 0; txn_who = pick; gnt = pick; rr = 1 - pick;
        last_addr = a[pick]; last_wdata = wd[pick];
        txn_rm = rm[pick]; txn_wm = wm[pick];
      end
      if (lk_owner >= 0) begin
        if (lk_age >= int'(MAXL)) tmo = 1;
        if (!lk[lk_owner] || fl[lk_owner]) begin
          lk_owner = -1; lk_age = 0;
        end else begin
          lk_age++;
        end
      end else if (acq >= 0) begin
        lk_owner = acq; lk_word = la[acq][31:2]; lk_age = 0;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    for (int k = 0; k < 2; k++) begin
      a[k] = '0; wd[k] = '0; la[k] = '0; rm[k] = '0; wm[k] = '0; lk[k] = 0; fl[k] = 0;
    end
    mresp = 0; mrdata = '0;
  endtask

  task automatic do_reset();
    rst = 1; step(); rst = 0;
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom % 4)
      0: return 32'h0000_0100;
      1: return 32'h0000_0200;
      2: return 32'h0000_0202;
      default: return 32'h0000_0300;
    endcase
  endfunction

  bit act[2];
  int lcnt[2];

  initial begin
    idle_inputs();
    rst = 1;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // reset state
    step();
    check_eq("rst_grant", 32'(o_gnt), 32'h0);
    check_eq("rst_rmask", 32'(o_rmask), 32'h0);
    check_eq("rst_timeout", 32'(o_tmo), 32'h0);

    // single read, memory answers on the third BUSY cycle
    rm[0] = 4'hF; a[0] = 32'h100;
    for (int c = 0; c < 4; c++) begin
      mresp = (c == 3); mrdata = (c == 3) ? 32'hDEAD_BEEF : 32'h0;
      step();
      if (c >= 1) check_eq("single_rmask", 32'(o_rmask), 32'hF);
      if (c == 3) begin
        check_eq("single_resp0", 32'(o_resp[0]), 32'h1);
        check_eq("single_rdata0", o_rd[0], 32'hDEAD_BEEF);
        check_eq("single_resp1", 32'(o_resp[1]), 32'h0);
      end
    end
    idle_inputs(); step();

    // round robin with continuous requests from both harts
    do_reset();
    rm[0] = 4'hF; a[0] = 32'h400; rm[1] = 4'h3; a[1] = 32'h500; mresp = 1;
    for (int c = 0; c < 8; c++) begin
      mrdata = 32'h1000 + 32'(c);
      step();
      check_eq("rr_order", 32'({o_resp[1], o_resp[0]}),
               (c % 2 == 1) ? (((c / 2) % 2 == 1) ? 32'h2 : 32'h1) : 32'h0);
    end
    idle_inputs(); step();

    // hart 0 locks 0x200; hart 1 write to the same word waits for release
    lk[0] = 1; la[0] = 32'h200; step();
    wm[1] = 4'hF; a[1] = 32'h200; wd[1] = 32'hCAFE_0001; mresp = 1;
    for (int c = 1; c <= 6; c++) begin
      lk[0] = (c < 4);
      step();
      check_eq("lock_blocked_resp1", 32'(o_resp[1]), (c == 6) ? 32'h1 : 32'h0);
    end
    idle_inputs(); step();
    lk[0] = 1; la[0] = 32'h200; step();
    wm[1] = 4'h1; a[1] = 32'h300; wd[1] = 32'hCAFE_0002; mresp = 1;
    step(); step();
    check_eq("lock_other_word_resp1", 32'(o_resp[1]), 32'h1);
    idle_inputs(); step(); step();

    // flush of the granted hart while BUSY drains without a response
    wm[1] = 4'hF; a[1] = 32'h600; wd[1] = 32'h1234_5678;
    for (int c = 0; c < 6; c++) begin
      fl[1] = (c == 1);
      if (c >= 2) wm[1] = 4'h0;
      mresp = (c >= 3);
      if (c >= 4) begin rm[0] = 4'hF; a[0] = 32'h700; end
      step();
      check_eq("flush_resp1", 32'(o_resp[1]), 32'h0);
      if (c >= 1 && c <= 3) check_eq("flush_wmask_held", 32'(o_wmask), 32'hF);
      if (c == 5) check_eq("flush_next_resp0", 32'(o_resp[0]), 32'h1);
    end
    idle_inputs(); step();

    // watchdog: 4 cycles of ownership is fine, 5 trips it
    for (int c = 0; c < 8; c++) begin
      lk[0] = (c < 4); la[0] = 32'h800;
      step();
    end
    check_eq("wdog_at_limit", 32'(o_tmo), 32'h0);
    for (int c = 0; c < 8; c++) begin
      lk[0] = (c < 5);
      step();
    end
    check_eq("wdog_sticky", 32'(o_tmo), 32'h1);
    do_reset();
    step();
    check_eq("wdog_rst_clear", 32'(o_tmo), 32'h0);

    // random traffic
    idle_inputs();
    act[0] = 0; act[1] = 0; lcnt[0] = 0; lcnt[1] = 0;
    for (int n = 0; n < 4000; n++) begin
      for (int k = 0; k < 2; k++) begin
        if (act[k] && (m_resp[k] || fl[k])) act[k] = 0;
        fl[k] = ($urandom % 16 == 0);
        if (!act[k] && ($urandom % 3 == 0)) begin
          act[k] = 1; a[k] = pick_addr(); wd[k] = $urandom;
          if ($urandom % 2 == 1) begin
            rm[k] = 4'($urandom_range(1, 15)); wm[k] = 4'h0;
          end else begin
            rm[k] = 4'h0; wm[k] = 4'($urandom_range(1, 15));
          end
        end
        if (!act[k]) begin rm[k] = 4'h0; wm[k] = 4'h0; end
        if (lcnt[k] > 0) begin
          lcnt[k]--; lk[k] = 1;
        end else if ($urandom % 10 == 0) begin
          lcnt[k] = int'($urandom_range(0, 5)); lk[k] = 1; la[k] = pick_addr();
        end else begin
          lk[k] = 0;
        end
      end
      mresp = ($urandom % 3 == 0);
      mrdata = $urandom;
      rst = ($urandom % 150 == 0);
      step();
    end
    rst = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
